mul16_seq_ctrl: RTL

Sequencer that computes a 16x16 unsigned product by time-multiplexing a single external 8x8 approximate multiplier core (LUT2_1134-class, or any 8x8 core with a combinational 16-bit product). It replaces the four parallel 8x8 instances with one shared core. Operands are split into high and low bytes and one partial product is issued per cycle. Partials are accumulated with shift-add into a 32-bit result, and the result is returned through a valid/ready handshake. The block sits between an operand producer and a result consumer wherever area matters more than throughput.

---
 rtl/mul16_seq_ctrl_if.sv | 43 ++++
 rtl/mul16_seq_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mul16_seq_ctrl_if.sv
// Operand, result and shared-core signals of the sequential 16x16 multiplier.
// The slave side is the sequencer; the master side is the producer/consumer plus core.
interface mul16_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] prod;
  logic        busy;

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  mul_p,
    input  out_ready,
    output in_ready,
    output mul_a,
    output mul_b,
    output out_valid,
    output prod,
    output busy
  );

  modport master (
    output in_valid,
    output a,
    output b,
    output mul_p,
    output out_ready,
    input  in_ready,
    input  mul_a,
    input  mul_b,
    input  out_valid,
    input  prod,
    input  busy
  );
endinterface

// File: rtl/mul16_seq_ctrl.sv
// 16x16 unsigned multiply sequenced over one shared 8x8 core, one byte-pair per cycle,
// shift-add accumulated into a 32-bit result returned over a valid/ready handshake.
module mul16_seq_ctrl #(
  parameter bit TRUNC_LL = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  mul16_seq_ctrl_if.slave bus
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLl   = 3'd1;
  localparam logic [2:0] StLh   = 3'd2;
  localparam logic [2:0] StHl   = 3'd3;
  localparam logic [2:0] StHh   = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] prod_q, prod_d;
  logic        out_valid_q, out_valid_d;

  logic [7:0]  al, ah, bl, bh;
  logic [7:0]  mul_a, mul_b;
  logic [31:0] partial;
  logic        compute;
  logic        accept;

  assign al = a_q[7:0];
  assign ah = a_q[15:8];
  assign bl = b_q[7:0];
  assign bh = b_q[15:8];

  // Core operands and the aligned partial product depend on the state alone.
  always_comb begin
    mul_a   = 8'h00;
    mul_b   = 8'h00;
    partial = 32'h0;
    compute = 1'b0;
    case (state_q)
      StLl: begin
        mul_a   = al;
        mul_b   = bl;
        partial = {16'h0, bus.mul_p};
        compute = 1'b1;
      end
      StLh: begin
        mul_a   = al;
        mul_b   = bh;
        partial = {8'h0, bus.mul_p, 8'h0};
        compute = 1'b1;
      end
      StHl: begin
        mul_a   = ah;
        mul_b   = bl;
        partial = {8'h0, bus.mul_p, 8'h0};
        compute = 1'b1;
      end
      StHh: begin
        mul_a   = ah;
        mul_b   = bh;
        partial = {bus.mul_p, 16'h0};
        compute = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = (state_q == StIdle) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = 32'h0;
          state_d = TRUNC_LL ? StLh : StLl;
        end
      end
      StLl:   state_d = StLh;
      StLh:   state_d = StHl;
      StHl:   state_d = StHh;
      StHh:   state_d = StDone;
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Modulo-2^32 wrap is intended: approximate cores may overshoot the exact product.
    if (compute) begin
      acc_d = acc_q + partial;
    end
  end

  // prod is only refreshed on the edge that enters DONE and otherwise holds.
  assign prod_d      = (state_q == StHh) ? acc_d : prod_q;
  assign out_valid_d = (state_d == StDone);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= 16'h0;
      b_q         <= 16'h0;
      acc_q       <= 32'h0;
      prod_q      <= 32'h0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.mul_a     = mul_a;
  assign bus.mul_b     = mul_b;
  assign bus.out_valid = out_valid_q;
  assign bus.prod      = prod_q;

endmodule
